ulpi_reg_ctrl: RTL and testbench

- Sequences ULPI PHY register reads and writes over the link's transmit-command interface (cmd / cmd_strobe / cmd_busy).
- Collects read data from the link's RX-command path.
- Sits between a single register-access requester (config FSM or CSR bridge) and the ULPI link block.
- Provides one outstanding transaction, a response pulse and a no-response timeout.

---
 rtl/ulpi_pkg.sv | 33 +++
 rtl/ulpi_reg_ctrl_if.sv | 43 ++++
 rtl/ulpi_timeout_ctr.sv | 42 ++++
 rtl/ulpi_reg_ctrl.sv | 159 +++++++++++++++
 tb/tb_ulpi_reg_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ulpi_pkg.sv
// ULPI register-access definitions shared by the link-side controllers.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ulpi_pkg;

    // Transmit-command prefixes; the low six bits carry the immediate address.
    typedef enum logic [7:0] {
        NOOP      = 8'h00,
        REG_WRITE = 8'h80,
        REG_READ  = 8'hC0
    } ulpi_cmd_e;

    // Extended-register escape address; the controller rejects it.
    localparam logic [5:0] EXT_REG_ADDR = 6'h2F;

    // Register-controller states, one-hot.
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_W_ADDR = 6'b000010,
        ST_W_DATA = 6'b000100,
        ST_R_ADDR = 6'b001000,
        ST_R_WAIT = 6'b010000,
        ST_DONE   = 6'b100000
    } reg_state_e;

    // Build the command byte for an immediate register access.
    function automatic logic [7:0] reg_cmd(input logic write, input logic [5:0] addr);
        logic [7:0] pfx;
        pfx = write ? REG_WRITE : REG_READ;
        return {pfx[7:6], addr};
    endfunction

endpackage

// File: rtl/ulpi_reg_ctrl_if.sv
// Request/response and link TX/RX-command signals of the register controller.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests, cmd_busy stalls the TX byte.
interface ulpi_reg_ctrl_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;

    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;

    logic [7:0] cmd;
    logic       cmd_strobe;
    logic       cmd_busy;

    logic [7:0] rx_cmd;
    logic       rx_cmd_strobe;

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output cmd, cmd_strobe,
        input  cmd_busy,
        input  rx_cmd, rx_cmd_strobe
    );

    // Requester plus link side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  cmd, cmd_strobe,
        output cmd_busy,
        output rx_cmd, rx_cmd_strobe
    );

endinterface

// File: rtl/ulpi_timeout_ctr.sv
// Saturating cycle counter with synchronous clear and expiry flag.
// Latency: expired_o reflects the registered count (one cycle after en_i).
// Backpressure: none; counts only while en_i is high, never wraps.
module ulpi_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] SAT  = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear on load, otherwise count up and hold once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// Sequences one ULPI register read or write over the link TX-command port.
// Latency: write 4 cycles accept->resp_valid (+busy), read 3 + PHY turnaround.
// Backpressure: one outstanding request; cmd/cmd_strobe hold while cmd_busy.
module ulpi_reg_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    ulpi_reg_ctrl_if.slave  bus
);

    import ulpi_pkg::*;

    reg_state_e st_q, st_d;
    logic [7:0] cmd_q, cmd_d;
    logic       stb_q, stb_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;

    logic       resp_valid_q;
    logic [7:0] resp_rdata_q;
    logic       resp_err_q;

    logic       accept;
    logic       consume;
    logic       ctr_load;
    logic       ctr_en;
    logic       ctr_expired;

    // Ready is withheld while reset is asserted even though state is IDLE.
    assign bus.req_ready = (st_q == ST_IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign consume       = stb_q && !bus.cmd_busy;

    ulpi_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ctr_load),
        .en_i      (ctr_en),
        .expired_o (ctr_expired)
    );

    // Next-state and TX byte sequencing.
    always_comb begin
        st_d     = st_q;
        cmd_d    = cmd_q;
        stb_d    = stb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.req_addr == EXT_REG_ADDR) begin
                        err_d   = 1'b1;
                        rdata_d = 8'h00;
                        st_d    = ST_DONE;
                    end else begin
                        wdata_d = bus.req_wdata;
                        cmd_d   = reg_cmd(bus.req_write, bus.req_addr);
                        stb_d   = 1'b1;
                        st_d    = bus.req_write ? ST_W_ADDR : ST_R_ADDR;
                    end
                end
            end
            ST_W_ADDR: begin
                if (consume) begin
                    cmd_d = wdata_q;
                    st_d  = ST_W_DATA;
                end
            end
            ST_W_DATA: begin
                if (consume) begin
                    stb_d   = 1'b0;
                    cmd_d   = NOOP;
                    err_d   = 1'b0;
                    rdata_d = 8'h00;
                    st_d    = ST_DONE;
                end
            end
            ST_R_ADDR: begin
                if (consume) begin
                    stb_d    = 1'b0;
                    cmd_d    = NOOP;
                    ctr_load = 1'b1;
                    st_d     = ST_R_WAIT;
                end
            end
            ST_R_WAIT: begin
                // Data arriving on the expiry cycle still counts as a success.
                if (bus.rx_cmd_strobe) begin
                    rdata_d = bus.rx_cmd;
                    err_d   = 1'b0;
                    st_d    = ST_DONE;
                end else if (ctr_expired) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    st_d    = ST_DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_DONE: begin
                st_d = ST_IDLE;
            end
            default: begin
                // Any non-one-hot encoding falls back to a clean idle.
                st_d  = ST_IDLE;
                stb_d = 1'b0;
                cmd_d = NOOP;
            end
        endcase
    end

    // Controller state and TX byte registers; reset drops cmd_strobe at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= ST_IDLE;
            cmd_q   <= 8'h00;
            stb_q   <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cmd_q   <= cmd_d;
            stb_q   <= stb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Registered one-cycle response, issued for the cycle spent in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 8'h00;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= (st_q == ST_DONE);
            resp_rdata_q <= (st_q == ST_DONE) ? rdata_q : 8'h00;
            resp_err_q   <= (st_q == ST_DONE) ? err_q : 1'b0;
        end
    end

    assign bus.cmd        = cmd_q;
    assign bus.cmd_strobe = stb_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Bench for ulpi_reg_ctrl: directed and random register accesses against a
// transaction-level model (byte list, latency, response fields).
// Link busy, PHY turnaround and stray RX strobes are injected by the bench.
module tb_ulpi_reg_ctrl;

    localparam int T = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ulpi_reg_ctrl_if bus ();

    ulpi_reg_ctrl #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. b = busy cycles per TX byte, k = cycles after
    // the read command is consumed before the PHY data appears.
    task automatic run_txn(input bit wr, input logic [5:0] addr, input logic [7:0] wd,
                           input int b, input int k, input logic [7:0] rd, input string tag);
        logic [7:0] exp_bytes[$];
        logic [7:0] got[$];
        int         exp_lat, wait_cyc;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         busy_cnt, c_read, resp_cnt, resp_n, stb_seen;
        logic [7:0] r_rd, prev_cmd;
        logic       r_err;
        bit         prev_busy;

        // Reference model.
        if (addr == 6'h2F) begin
            exp_lat   = 2;
            exp_err   = 1'b1;
            exp_rdata = 8'h00;
        end else if (wr) begin
            exp_bytes.push_back(8'h80 | {2'b00, addr});
            exp_bytes.push_back(wd);
            exp_lat   = 2 * (1 + b) + 2;
            exp_err   = 1'b0;
            exp_rdata = 8'h00;
        end else begin
            exp_bytes.push_back(8'hC0 | {2'b00, addr});
            wait_cyc  = (k + 1 < T) ? k + 1 : T;
            exp_lat   = (1 + b) + 2 + wait_cyc;
            exp_err   = (k < T) ? 1'b0 : 1'b1;
            exp_rdata = (k < T) ? rd : 8'h00;
        end

        busy_cnt = 0; c_read = -1; resp_cnt = 0; resp_n = -1; stb_seen = 0;
        prev_busy = 1'b0; prev_cmd = 8'h00; r_rd = 8'h00; r_err = 1'b0;

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        check({tag, ".ready"}, bus.req_ready, 1);
        tick();

        for (int n = 1; n <= exp_lat + 1; n++) begin
            // Requests while busy must be ignored.
            bus.req_valid = (n < exp_lat) ? 1'($urandom) : 1'b0;
            bus.req_write = 1'($urandom);
            bus.req_addr  = 6'($urandom);
            bus.req_wdata = 8'($urandom);

            if (prev_busy) begin
                check({tag, ".stb_hold"}, bus.cmd_strobe, 1);
                check({tag, ".cmd_hold"}, bus.cmd, prev_cmd);
            end

            bus.cmd_busy = 1'b0;
            if (bus.cmd_strobe) begin
                stb_seen++;
                if (busy_cnt < b) begin
                    bus.cmd_busy = 1'b1;
                    busy_cnt++;
                end else begin
                    got.push_back(bus.cmd);
                    busy_cnt = 0;
                    if (!wr) c_read = n;
                end
            end
            prev_busy = bus.cmd_strobe && bus.cmd_busy;
            prev_cmd  = bus.cmd;

            bus.rx_cmd        = 8'($urandom);
            bus.rx_cmd_strobe = 1'b0;
            if (c_read >= 0 && n == c_read + 1 + k) begin
                bus.rx_cmd_strobe = 1'b1;
                bus.rx_cmd        = rd;
            end else if (c_read < 0) begin
                bus.rx_cmd_strobe = ($urandom_range(0, 3) == 0);
            end

            if (bus.resp_valid) begin
                resp_cnt++;
                resp_n = n;
                r_rd   = bus.resp_rdata;
                r_err  = bus.resp_err;
            end
            if (n == exp_lat) begin
                check({tag, ".stb_end"}, bus.cmd_strobe, 0);
                check({tag, ".cmd_end"}, bus.cmd, 0);
            end
            if (n == exp_lat + 1) check({tag, ".ready_after"}, bus.req_ready, 1);
            tick();
        end
        bus.req_valid     = 1'b0;
        bus.cmd_busy      = 1'b0;
        bus.rx_cmd_strobe = 1'b0;

        check({tag, ".resp_cnt"}, resp_cnt, 1);
        check({tag, ".latency"}, resp_n, exp_lat);
        check({tag, ".rdata"}, r_rd, exp_rdata);
        check({tag, ".err"}, r_err, exp_err);
        check({tag, ".stb_cycles"}, stb_seen, exp_bytes.size() * (1 + b));
        check({tag, ".nbytes"}, got.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++)
            check({tag, ".byte"}, got[i], exp_bytes[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         wr;
        logic [5:0] ra;
        logic [7:0] wd, rd;
        int         b, k;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 6'h00; bus.req_wdata = 8'h00;
        bus.cmd_busy = 1'b0; bus.rx_cmd = 8'h00; bus.rx_cmd_strobe = 1'b0;

        tick();
        tick();
        check("rst.req_ready", bus.req_ready, 0);
        check("rst.resp_valid", bus.resp_valid, 0);
        check("rst.resp_rdata", bus.resp_rdata, 0);
        check("rst.resp_err", bus.resp_err, 0);
        check("rst.cmd", bus.cmd, 0);
        check("rst.cmd_strobe", bus.cmd_strobe, 0);
        reset = 1'b0;
        #1;
        check("rst.ready_release", bus.req_ready, 1);

        run_txn(1'b1, 6'h0A, 8'h55, 0, 0, 8'h00, "wr");
        run_txn(1'b0, 6'h00, 8'h00, 0, 4, 8'h24, "rd");
        run_txn(1'b1, 6'h0A, 8'h55, 3, 0, 8'h00, "wr_busy");
        run_txn(1'b0, 6'h05, 8'h00, 0, 100, 8'hAA, "rd_timeout");
        run_txn(1'b1, 6'h2F, 8'h12, 0, 0, 8'h00, "ext_wr");
        run_txn(1'b0, 6'h2F, 8'h00, 0, 0, 8'h77, "ext_rd");
        run_txn(1'b0, 6'h16, 8'h00, 1, T - 1, 8'h3C, "rd_edge_data");
        run_txn(1'b0, 6'h16, 8'h00, 0, T, 8'h3C, "rd_edge_late");
        run_txn(1'b0, 6'h3F, 8'h00, 2, 0, 8'hE1, "rd_fast");

        // Reset while the write data byte is on the bus.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 6'h0A; bus.req_wdata = 8'h55;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("arst.cmd_pre", bus.cmd, 8'h55);
        check("arst.stb_pre", bus.cmd_strobe, 1);
        reset = 1'b1;
        #1;
        check("arst.stb_drop", bus.cmd_strobe, 0);
        check("arst.ready_low", bus.req_ready, 0);
        tick();
        check("arst.no_resp_in", bus.resp_valid, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("arst.no_resp", bus.resp_valid, 0);
            check("arst.stb_idle", bus.cmd_strobe, 0);
            check("arst.ready", bus.req_ready, 1);
            tick();
        end
        run_txn(1'b1, 6'h0A, 8'h55, 0, 0, 8'h00, "wr_after_rst");

        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? 6'h2F : 6'($urandom);
            wd = 8'($urandom);
            rd = 8'($urandom);
            b  = $urandom_range(0, 3);
            k  = $urandom_range(0, T + 4);
            run_txn(wr, ra, wd, b, k, rd, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
